// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a 7-bit bus address, a pointer byte and
// an NREG x 8-bit register file. The bus is sampled with clk through 2-FF
// synchronizers; SDA is only ever pulled low (open-drain) and only changes
// after a detected SCL falling edge.
// Optional feature macro: I2C_GEN_CALL_EN (general-call reset, command 8'h06).
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'b1101111,
  parameter int         NREG        = 8,
  parameter int         PTR_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             reg_wr_valid,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK, ST_WDATA, ST_WDATA_ACK,
    ST_RDATA, ST_RDATA_ACK, ST_GC_DATA, ST_GC_ACK, ST_GC_WAIT
  } state_t;

  // Bus synchronizers plus one history stage for edge detection
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  // Protocol state
  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [7:0]       shift_q;
  logic [6:0]       tx_q;
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q;
  logic             mack_q;
  logic             sda_oe_q;
  logic             busy_q;
  logic             wr_valid_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             clr_q;
`ifdef I2C_GEN_CALL_EN
  logic             gc_q;
  logic             gc_cmd_q;
`endif

  logic [7:0] regs_q [NREG];

  // Decoded bus events and helper values
  logic             scl_rise_d, scl_fall_d, start_d, stop_d;
  logic [7:0]       shift_in_d;
  logic [PTR_W-1:0] ptr_inc_d;
  logic [7:0]       rd_cur_d, rd_nxt_d;
  logic             addr_match_d;

  assign scl_rise_d   = scl_s2_q & ~scl_h_q;
  assign scl_fall_d   = ~scl_s2_q & scl_h_q;
  assign start_d      = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_d       = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shift_in_d   = {shift_q[6:0], sda_s2_q};
  assign ptr_inc_d    = ptr_q + PTR_W'(1);
  assign rd_cur_d     = regs_q[ptr_q];
  assign rd_nxt_d     = regs_q[ptr_inc_d];
  assign addr_match_d = (shift_q[7:1] == TARGET_ADDR);

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  // Old contents are visible during the write pulse; the array updates at its end
  assign host_rdata   = regs_q[host_addr];

  // Synchronize SCL/SDA; reset to the idle-high bus level so no false START
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
      sda_s1_q <= sda_i; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
    end
  end

  // Protocol FSM: bits shift in on SCL rise, SDA drive changes only on SCL fall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 7'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      clr_q      <= 1'b0;
`ifdef I2C_GEN_CALL_EN
      gc_q       <= 1'b0;
      gc_cmd_q   <= 1'b0;
`endif
    end else begin
      wr_valid_q <= 1'b0;
      clr_q      <= 1'b0;
      if (stop_d) begin
        // STOP discards any partial byte and releases the bus
        state_q  <= ST_IDLE;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_d) begin
        // (Repeated) START: pointer is deliberately kept
        state_q  <= ST_ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_rise_d && cnt_q < 4'd8) begin
              shift_q <= shift_in_d;
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_d && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              if (addr_match_d) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= shift_q[0];
                state_q  <= ST_ADDR_ACK;
`ifdef I2C_GEN_CALL_EN
                gc_q     <= 1'b0;
              end else if (shift_q == 8'h00) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= 1'b0;
                gc_q     <= 1'b1;
                state_q  <= ST_ADDR_ACK;
`endif
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_d) begin
              cnt_q <= 4'd0;
`ifdef I2C_GEN_CALL_EN
              if (gc_q) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_GC_DATA;
              end else
`endif
              if (rw_q) begin
                // First read byte is fetched and its MSB driven at this fall
                tx_q     <= rd_cur_d[6:0];
                sda_oe_q <= ~rd_cur_d[7];
                state_q  <= ST_RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (scl_rise_d && cnt_q < 4'd8) begin
              shift_q <= shift_in_d;
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_d && cnt_q == 4'd8) begin
              ptr_q    <= shift_q[PTR_W-1:0];
              sda_oe_q <= 1'b1;
              cnt_q    <= 4'd0;
              state_q  <= ST_PTR_ACK;
            end
          end
          ST_PTR_ACK: begin
            if (scl_fall_d) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (scl_rise_d && cnt_q < 4'd8) begin
              shift_q <= shift_in_d;
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_d && cnt_q == 4'd8) begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= ptr_q;
              wr_data_q  <= shift_q;
              ptr_q      <= ptr_inc_d;
              sda_oe_q   <= 1'b1;
              cnt_q      <= 4'd0;
              state_q    <= ST_WDATA_ACK;
            end
          end
          ST_WDATA_ACK: begin
            if (scl_fall_d) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise_d && cnt_q < 4'd8) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall_d && cnt_q == 4'd8) begin
              sda_oe_q <= 1'b0;
              cnt_q    <= 4'd0;
              state_q  <= ST_RDATA_ACK;
            end else if (scl_fall_d) begin
              sda_oe_q <= ~tx_q[6];
              tx_q     <= {tx_q[5:0], 1'b0};
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise_d) begin
              mack_q <= sda_s2_q;
            end else if (scl_fall_d && !mack_q) begin
              ptr_q    <= ptr_inc_d;
              tx_q     <= rd_nxt_d[6:0];
              sda_oe_q <= ~rd_nxt_d[7];
              state_q  <= ST_RDATA;
            end else if (scl_fall_d) begin
              sda_oe_q <= 1'b0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
`ifdef I2C_GEN_CALL_EN
          ST_GC_DATA: begin
            if (scl_rise_d && cnt_q < 4'd8) begin
              shift_q <= shift_in_d;
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall_d && cnt_q == 4'd8) begin
              gc_cmd_q <= (shift_q == 8'h06);
              sda_oe_q <= 1'b1;
              cnt_q    <= 4'd0;
              state_q  <= ST_GC_ACK;
            end
          end
          ST_GC_ACK: begin
            if (scl_rise_d && gc_cmd_q) begin
              clr_q <= 1'b1;
              ptr_q <= '0;
            end else if (scl_fall_d) begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_GC_WAIT;
            end
          end
          ST_GC_WAIT: begin
            sda_oe_q <= 1'b0;
          end
`endif
          default: begin
            sda_oe_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Register file: cleared by reset or general call, else written by the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else if (clr_q) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= 8'h00;
    end else if (wr_valid_q) begin
      regs_q[wr_addr_q] <= wr_data_q;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboard bench for i2c_target_regfile: a bus master BFM issues randomized
// and directed transactions, expected responses come from a transaction-level
// register/pointer model and are compared by a separate monitor process.
module tb_i2c_target_regfile;
  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [2:0] host_addr = 3'd0;
  logic       sda_oe, reg_wr_valid, busy;
  logic [2:0] reg_wr_addr;
  logic [7:0] reg_wr_data, host_rdata;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .host_addr(host_addr), .host_rdata(host_rdata),
    .busy(busy)
  );

  typedef struct { int addr; int data; int old; } wr_t;

  int   errors = 0;
  int   checks = 0;
  int   model_regs [8];
  int   model_ptr = 0;
  wr_t  wr_exp[$];
  int   bus_exp[$];
  int   bus_obs[$];
  int   wdata[$];
  logic watch = 1'b0;
  int   drive_seen = 0;
  int   busy_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: write-port pulses and observed bus responses against expectations
  initial begin
    logic prev_valid;
    wr_t  e;
    int   o, x;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_wr_valid) begin
        chk("wr_pulse_width", int'(prev_valid), 0);
        if (wr_exp.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = wr_exp.pop_front();
          chk("wr_addr", int'(reg_wr_addr), e.addr);
          chk("wr_data", int'(reg_wr_data), e.data);
          chk("host_old_during_write", int'(host_rdata), e.old);
        end
      end
      prev_valid = reg_wr_valid;
      if (watch) begin
        if (sda_oe) drive_seen++;
        if (busy) busy_seen++;
      end
      if (bus_obs.size() > 0) begin
        o = bus_obs.pop_front();
        if (bus_exp.size() == 0) begin
          chk("bus_unexpected", o, -1);
        end else begin
          x = bus_exp.pop_front();
          chk((x >> 8) == 1 ? "ack_bit" : "read_byte", o & 255, x & 255);
        end
      end
    end
  end

  // Global time bound
  initial begin
    #800000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_w(input logic b);
    sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic bit_r(output logic b);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); b = sda_bus; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic do_start();
    sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic do_rstart();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait(); qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, input int exp_ack);
    logic a;
    bus_exp.push_back(256 + exp_ack);
    for (int i = 7; i >= 0; i--) bit_w(b[i]);
    bit_r(a);
    bus_obs.push_back(256 + int'(a));
  endtask

  task automatic recv_byte(input int expb, input logic mack);
    logic       b;
    logic [7:0] v;
    bus_exp.push_back(512 + expb);
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      v[i] = b;
    end
    bus_obs.push_back(512 + int'(v));
    bit_w(mack);
  endtask

  task automatic end_check();
    repeat (4) @(negedge clk);
    chk("sda_oe_after_stop", int'(sda_oe), 0);
    chk("busy_after_stop", int'(busy), 0);
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      host_addr = 3'(i);
      @(negedge clk);
      chk("host_rdata", int'(host_rdata), model_regs[i]);
    end
  endtask

  // Write transaction: pointer byte then the bytes queued in wdata
  task automatic wr_txn(input int ptrb, input bit stop);
    int d;
    do_start();
    send_byte(8'hDE, 0);
    chk("busy_after_match", int'(busy), 1);
    send_byte(8'(ptrb), 0);
    model_ptr = ptrb % 8;
    while (wdata.size() > 0) begin
      d = wdata.pop_front();
      host_addr = 3'(model_ptr);
      wr_exp.push_back('{model_ptr, d, model_regs[model_ptr]});
      model_regs[model_ptr] = d;
      model_ptr = (model_ptr + 1) % 8;
      send_byte(8'(d), 0);
    end
    if (stop) begin
      do_stop();
      end_check();
    end
  endtask

  // Read transaction of n bytes from the current pointer; last byte NACKed
  task automatic rd_txn(input int n, input bit rep);
    int e;
    if (rep) do_rstart(); else do_start();
    send_byte(8'hDF, 0);
    chk("busy_in_read", int'(busy), 1);
    for (int i = 0; i < n; i++) begin
      e = model_regs[model_ptr];
      if (i < n - 1) model_ptr = (model_ptr + 1) % 8;
      recv_byte(e, (i < n - 1) ? 1'b0 : 1'b1);
    end
    chk("busy_after_nack", int'(busy), 0);
    do_stop();
    end_check();
  endtask

  task automatic bad_txn(input logic [7:0] ab);
    watch = 1'b1; drive_seen = 0; busy_seen = 0;
    do_start();
    send_byte(ab, 1);
    do_stop();
    watch = 1'b0;
    chk("wrong_addr_sda_oe", drive_seen, 0);
    chk("wrong_addr_busy", busy_seen, 0);
  endtask

  initial begin
    logic b;
    int   op, p, ab;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_valid", int'(reg_wr_valid), 0);
    chk("rst_wr_addr", int'(reg_wr_addr), 0);
    chk("rst_wr_data", int'(reg_wr_data), 0);
    sweep();
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Single write to register 2
    wdata = '{8'hCC};
    wr_txn(2, 1'b1);
    host_addr = 3'd2;
    @(negedge clk);
    chk("host_reg2", int'(host_rdata), 8'hCC);

    // Burst write wrapping 7 -> 0
    wdata = '{8'h11, 8'h22};
    wr_txn(7, 1'b1);
    sweep();

    // Pointer write, repeated START, read two bytes across the wrap
    wr_txn(7, 1'b0);
    rd_txn(2, 1'b1);

    // Non-matching address
    bad_txn(8'hA0);

    // STOP after four data bits: nothing written
    do_start();
    send_byte(8'hDE, 0);
    send_byte(8'h05, 0);
    model_ptr = 5;
    for (int i = 0; i < 4; i++) bit_w(1'($urandom_range(0, 1)));
    do_stop();
    end_check();
    sweep();

    // General call
`ifdef I2C_GEN_CALL_EN
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h06, 0);
    do_stop();
    end_check();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_ptr = 0;
    sweep();
`else
    bad_txn(8'h00);
`endif

    // Reset in the middle of a read byte
    wdata = '{8'h0F};
    wr_txn(3, 1'b1);
    wr_txn(3, 1'b0);
    do_rstart();
    send_byte(8'hDF, 0);
    bit_r(b);
    bit_r(b);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait();
    chk("sda_oe_before_reset", int'(sda_oe), 1);
    reset = 1'b0;
    #1;
    chk("sda_oe_on_reset", int'(sda_oe), 0);
    chk("busy_on_reset", int'(busy), 0);
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_ptr = 0;
    sweep();
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 20; t++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          p = int'($urandom_range(1, 4));
          for (int k = 0; k < p; k++) wdata.push_back(int'($urandom_range(0, 255)));
          wr_txn(int'($urandom_range(0, 255)), 1'b1);
        end
        1: begin
          wr_txn(int'($urandom_range(0, 255)), 1'b0);
          rd_txn(int'($urandom_range(1, 3)), 1'b1);
        end
        2: rd_txn(int'($urandom_range(1, 3)), 1'b0);
        default: begin
          ab = int'($urandom_range(2, 255));
          while ((ab >> 1) == 'h6F) ab = int'($urandom_range(2, 255));
          bad_txn(8'(ab));
        end
      endcase
    end

    sweep();
    repeat (20) @(negedge clk);
    chk("wr_exp_drained", wr_exp.size(), 0);
    chk("bus_exp_drained", bus_exp.size(), 0);
    chk("bus_obs_drained", bus_obs.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C responder (target) with 7-bit address and an internal register file, behind a pointer byte.
- Sits on the shared scl/sda bus opposite the existing master and is the synthesizable replacement for the behavioural slave.
- Samples the bus with the system clk through synchronizers.
- Exposes a local write-notify port and a host read port for the rest of the design.

Parameters:
- TARGET_ADDR, 7'b1101111, bus address this block responds to.
- NREG, 8, number of 8-bit registers; power of two, 2..256.
- PTR_W, 3, pointer width; must equal log2(NREG).

Ports:
- clk  input  1  system clock; must be >= 10x SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL pin value.
- sda_i  input  1  SDA pin value.
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain).
- reg_wr_valid  output  1  one-cycle pulse when the bus writes a register.
- reg_wr_addr  output  PTR_W  register index written.
- reg_wr_data  output  8  data written.
- host_addr  input  PTR_W  local read index.
- host_rdata  output  8  combinational read of reg[host_addr].
- busy  output  1  high from address match until STOP or NACK-idle.

Behaviour:
- Reset (reset=0, async), all of the following:
  - sda_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0.
  - State=IDLE, pointer=0, all registers=8'h00.
- Synchronizers:
  - 2-FF synchronizer on scl_i and sda_i, plus one history FF for edge detection.
  - sda_oe updates on the clk after a detected SCL falling edge, so pin-to-drive latency is 3 clk.
- Bus events:
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - Data bits are sampled on the SCL rising edge, MSB first.
  - sda_oe changes only after an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE → ADDR on START.
- ADDR: shift 8 bits (addr[6:0], rw).
  - Address match: drive ACK (sda_oe=1) during the 9th clock; busy=1.
  - rw=0 → PTR. rw=1 → RDATA.
  - Mismatch: no ACK, return to IDLE, ignore the bus until the next START.
- PTR: 8 bits; pointer = byte[PTR_W-1:0] (upper bits ignored); ACK; → WDATA.
- WDATA: 8 bits per byte.
  - Write reg[pointer]; pulse reg_wr_valid for exactly one clk with the index and data.
  - ACK; pointer = pointer+1, wrapping NREG-1 → 0.
  - Repeat until STOP or repeated START.
- RDATA:
  - Load reg[pointer] at the SCL falling edge after the ACK.
  - Drive bits MSB first: sda_oe = ~bit. Release on the falling edge after bit 0.
  - RDATA_ACK samples the master's bit. ACK (0): pointer+1 with wrap, → RDATA. NACK (1): → IDLE, busy=0.
- Boundary conditions:
  - STOP in any state → IDLE, sda_oe=0 within 3 clk, busy=0. A partial byte is discarded; no write occurs.
  - START in any state (repeated START) → ADDR. Pointer is retained, so write-pointer/repeated-START/read works.
  - Pointer wraps silently on overflow.
  - A host_addr read of a register during the same-cycle bus write returns the old value.
  - reset asserted mid-transfer aborts immediately and releases SDA.

Optional Feature:
- Macro: I2C_GEN_CALL_EN.
- Defined:
  - Address byte 8'h00 (general call, write) is ACKed and sets busy=1.
  - The next byte is ACKed; value 8'h06 clears all registers and pointer to 0, one clk after that ACK's SCL rising edge, with no reg_wr_valid pulses.
  - Any other value is ignored; the block then waits for STOP.
- Undefined: 8'h00 is treated as a non-matching address; no ACK.

Test Plan:
- Write: START, 0xDE (6F+W), ptr 0x02, data 0xCC, STOP → three ACKs; reg_wr_valid once with addr=2, data=0xCC; host_addr=2 reads 0xCC; busy low after STOP.
- Burst wrap: ptr 0x07, data 0x11, 0x22 → reg[7]=0x11, reg[0]=0x22; two one-cycle pulses.
- Read: ptr 0x07 write, repeated START, 0xDF, master ACK then NACK → SDA bits 0x11 then 0x22; SDA released after NACK; state IDLE.
- Wrong address: START, 0xA0 → no ACK; sda_oe stays 0 for the whole transfer; busy stays 0.
- Abort: STOP after 4 data bits of a write → no register change, sda_oe=0; reset pulse mid-read → sda_oe=0 immediately, registers=0.
- With I2C_GEN_CALL_EN: 0x00, 0x06 → both ACKed; all registers 0x00. Without it: 0x00 → NACK.
